// File: rtl/compressor_buff.sv
// Pair compressor: replaces adjacent instruction pairs matching the token table with one token word.
// Latency: 1 cycle from accepting a word into the hold register; outputs are registered in a single slot.
// Backpressure: in_ready = slot free && !flush && out of reset; output holds stable while !out_ready.
module compressor_buff #(
  parameter int                      WIDTH        = 32,
  parameter logic [WIDTH-1:0]        PCADD        = WIDTH'(3'b100),
  parameter int                      encodeLength = 4,
  parameter logic [encodeLength-1:0] OPcode       = 4'b1111,
  parameter int                      NTOK         = 16,
  parameter int                      IDXW         = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_instr,
  input  logic             flush,
  input  logic             wme,
  input  logic [IDXW-1:0]  widx,
  input  logic [WIDTH-1:0] wfirst,
  input  logic [WIDTH-1:0] wsecond,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_instr,
  output logic [WIDTH-1:0] PCcompress,
  output logic             illegal
);

  // Width of the token's address field below the marker.
  localparam int AW = WIDTH - encodeLength;
  localparam logic [AW-1:0] PCADD_A = AW'(PCADD);

  typedef enum logic {EMPTY, HOLD} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] held_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_instr_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic             ill_q;

  logic [WIDTH-1:0] tfirst_q  [NTOK];
  logic [WIDTH-1:0] tsecond_q [NTOK];
  logic [NTOK-1:0]  tvld_q;

  logic             slot_free;
  logic             accept;
  logic             marker;
  logic             match_hit;
  logic [IDXW-1:0]  match_idx;
  logic [AW-1:0]    tok_addr;
  logic [WIDTH-1:0] token;

  assign slot_free  = !out_valid_q || out_ready;
  assign in_ready   = slot_free && !flush && reset;
  assign accept     = in_valid && in_ready;
  assign marker     = (in_instr[WIDTH-1 -: encodeLength] == OPcode);
  assign pc_d       = pc_q + PCADD;

  assign out_valid  = out_valid_q;
  assign out_instr  = out_instr_q;
  assign PCcompress = pc_q;
  assign illegal    = ill_q;

  // Look up (held, incoming) in the table; scanning downward leaves the lowest matching index.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int i = NTOK - 1; i >= 0; i--) begin
      if (tvld_q[i] && (tfirst_q[i] == held_q) && (tsecond_q[i] == in_instr)) begin
        match_hit = 1'b1;
        match_idx = IDXW'(i);
      end
    end
  end

  // Token address is the byte address of the entry's first word: idx * 2 * PCADD.
  always_comb begin
    tok_addr = (AW'(match_idx) * PCADD_A) << 1;
    token    = {OPcode, tok_addr};
  end

  // Table contents are not cleared by reset; only the valid bits are.
  always_ff @(posedge clk) begin
    if (wme) begin
      tfirst_q[widx]  <= wfirst;
      tsecond_q[widx] <= wsecond;
    end
  end

  // Pairing FSM with registered output slot, address counter, sticky marker flag and table valid bits.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= EMPTY;
      held_q      <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      pc_q        <= '0;
      ill_q       <= 1'b0;
      tvld_q      <= '0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
        pc_q        <= pc_d;
      end
      if (wme) begin
        tvld_q[widx] <= 1'b1;
      end
      if (accept && marker) begin
        ill_q <= 1'b1;
      end
      case (state_q)
        EMPTY: begin
          if (accept) begin
            held_q  <= in_instr;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (flush && slot_free) begin
            out_instr_q <= held_q;
            out_valid_q <= 1'b1;
            state_q     <= EMPTY;
          end else if (accept) begin
            out_valid_q <= 1'b1;
            if (match_hit) begin
              out_instr_q <= token;
              state_q     <= EMPTY;
            end else begin
              out_instr_q <= held_q;
              held_q      <= in_instr;
            end
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_compressor_buff.sv
// Bench for compressor_buff: directed scenarios plus randomized traffic against a streaming pair model.
// Expected words are queued at acceptance time; an independent monitor pops them on each output handshake.
// Random out_ready stalls exercise backpressure and output stability.
module tb_compressor_buff;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        flush;
  logic        wme;
  logic [3:0]  widx;
  logic [31:0] wfirst;
  logic [31:0] wsecond;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] PCcompress;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  compressor_buff dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .flush(flush),
    .wme(wme), .widx(widx), .wfirst(wfirst), .wsecond(wsecond),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .PCcompress(PCcompress), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mfirst  [16];
  logic [31:0] msecond [16];
  bit          mvld    [16];
  logic [31:0] exp_q[$];
  bit          pend_vld;
  logic [31:0] pend;
  bit          ill_exp;

  function automatic int lookup(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 16; i++)
      if (mvld[i] && mfirst[i] == a && msecond[i] == b) return i;
    return -1;
  endfunction

  // Greedy left-to-right pairing: once the word after a pending one arrives, the pending word's fate is known.
  always @(negedge clk) begin
    if (!reset) begin
      pend_vld = 0;
      ill_exp  = 0;
      for (int i = 0; i < 16; i++) mvld[i] = 0;
      exp_q.delete();
    end else begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready) && !flush});
      chk("illegal", {31'd0, illegal}, {31'd0, ill_exp});
      if (in_valid && in_ready) begin
        if (in_instr[31:28] == 4'hF) ill_exp = 1;
        if (pend_vld) begin
          int k;
          k = lookup(pend, in_instr);
          if (k >= 0) begin
            exp_q.push_back({4'hF, 28'(k * 2 * 4)});
            pend_vld = 0;
          end else begin
            exp_q.push_back(pend);
            pend = in_instr;
          end
        end else begin
          pend     = in_instr;
          pend_vld = 1;
        end
      end else if (flush && (!out_valid || out_ready) && pend_vld) begin
        exp_q.push_back(pend);
        pend_vld = 0;
      end
      if (wme) begin
        mfirst[widx]  = wfirst;
        msecond[widx] = wsecond;
        mvld[widx]    = 1;
      end
    end
  end

  // ---------------- monitor ----------------
  logic [31:0] exp_pc;
  bit          stall_vld;
  logic [31:0] stall_word;

  always @(negedge clk) begin
    if (!reset) begin
      exp_pc    = 0;
      stall_vld = 0;
    end else begin
      if (stall_vld) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_data", out_instr, stall_word);
      end
      stall_vld = 0;
      if (out_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out", out_instr, 32'hxxxxxxxx);
          end else begin
            chk("out_instr", out_instr, exp_q.pop_front());
          end
          chk("PCcompress", PCcompress, exp_pc);
          exp_pc = exp_pc + 32'd4;
        end else begin
          stall_vld  = 1;
          stall_word = out_instr;
        end
      end
    end
  end

  // ---------------- random backpressure ----------------
  bit rand_rdy = 0;
  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- stimulus tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 0; in_valid = 0; flush = 0; wme = 0;
    tick(); tick();
    reset = 1;
  endtask

  task automatic send(input logic [31:0] x);
    bit done = 0;
    int n = 0;
    in_valid = 1;
    in_instr = x;
    while (!done && n < 200) begin
      @(negedge clk);
      done = in_ready;
      tick();
      n++;
    end
    in_valid = 0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_flush();
    bit done = 0;
    int n = 0;
    flush = 1;
    while (!done && n < 200) begin
      @(negedge clk);
      done = (!out_valid || out_ready);
      tick();
      n++;
    end
    flush = 0;
    if (!done) chk("flush_timeout", 32'd0, 32'd1);
  endtask

  task automatic write_entry(input logic [3:0] i, input logic [31:0] a, input logic [31:0] b);
    wme = 1; widx = i; wfirst = a; wsecond = b;
    tick();
    wme = 0;
  endtask

  task automatic drain();
    bit done = 0;
    int n = 0;
    out_ready = 1;
    while (!done && n < 300) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !out_valid;
      tick();
      n++;
    end
    chk("drain", {31'd0, done}, 32'd1);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #900000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  logic [31:0] alpha [6];

  initial begin
    in_valid = 0; in_instr = 0; flush = 0; wme = 0; widx = 0;
    wfirst = 0; wsecond = 0; out_ready = 1; reset = 0;
    do_reset();

    // Reset state
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_pc", PCcompress, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);

    // Matching pair -> token for entry 3
    write_entry(4'd3, 32'h00A00093, 32'h00108113);
    send(32'h00A00093);
    send(32'h00108113);
    do_flush();
    drain();
    chk("pc_after_token", PCcompress, 32'd4);

    // Three unmatched words
    do_reset();
    send(32'h11111111);
    send(32'h22222222);
    send(32'h33333333);
    do_flush();
    drain();
    chk("pc_after_raw3", PCcompress, 32'd12);

    // Pair split by a flush stays raw
    do_reset();
    write_entry(4'd3, 32'h00A00093, 32'h00108113);
    send(32'h00A00093);
    do_flush();
    send(32'h00108113);
    do_flush();
    drain();
    chk("pc_after_split", PCcompress, 32'd8);

    // Output stall for 5 cycles
    do_reset();
    out_ready = 0;
    send(32'h0000AAAA);
    send(32'h0000BBBB);
    repeat (5) tick();
    chk("stall_valid", {31'd0, out_valid}, 32'd1);
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1;
    do_flush();
    drain();

    // Marker conflict in a raw word
    send(32'hF0001234);
    do_flush();
    drain();
    chk("illegal_set", {31'd0, illegal}, 32'd1);
    send(32'h00000001);
    do_flush();
    drain();
    chk("illegal_sticky", {31'd0, illegal}, 32'd1);
    do_reset();
    chk("illegal_cleared", {31'd0, illegal}, 32'd0);

    // Table write in the same cycle as the second word -> raw
    send(32'h00A00093);
    in_valid = 1; in_instr = 32'h00108113;
    wme = 1; widx = 4'd0; wfirst = 32'h00A00093; wsecond = 32'h00108113;
    tick();
    in_valid = 0; wme = 0;
    do_flush();
    drain();
    chk("pc_same_cycle_write", PCcompress, 32'd8);

    // Write one cycle earlier -> token 0xF0000000
    do_reset();
    send(32'h00A00093);
    write_entry(4'd0, 32'h00A00093, 32'h00108113);
    send(32'h00108113);
    do_flush();
    drain();
    chk("pc_early_write", PCcompress, 32'd4);

    // Reset in the middle of a stalled transfer
    out_ready = 0;
    send(32'h12340000);
    send(32'h56780000);
    do_reset();
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_pc", PCcompress, 32'd0);
    out_ready = 1;

    // Randomized traffic over a small alphabet so table hits are frequent
    alpha[0] = 32'h00A00093; alpha[1] = 32'h00108113; alpha[2] = 32'h00000013;
    alpha[3] = 32'hDEADBEEF; alpha[4] = 32'hF000ABCD; alpha[5] = 32'h12345678;
    for (int i = 0; i < 6; i++)
      write_entry(4'($urandom_range(0, 15)), alpha[$urandom_range(0, 5)], alpha[$urandom_range(0, 5)]);
    rand_rdy = 1;
    for (int s = 0; s < 1500; s++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 5)
        write_entry(4'($urandom_range(0, 15)), alpha[$urandom_range(0, 5)], alpha[$urandom_range(0, 5)]);
      else if (r < 15)
        do_flush();
      else
        send(alpha[$urandom_range(0, 5)]);
    end
    do_flush();
    rand_rdy = 0;
    tick();
    drain();
    chk("final_pending", {31'd0, pend_vld}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
